// File: rtl/adc_chan_tx_if.sv
// adc_chan_tx_if: sample-word valid/ready handshake into adc_chan_tx.
// The chop_phase signal exists only when ADC_TX_CHOP_EN is defined.
interface adc_chan_tx_if;
  logic [17:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
`ifdef ADC_TX_CHOP_EN
  logic        chop_phase;
  modport master (output tx_data, tx_valid, chop_phase, input tx_ready);
  modport slave  (input tx_data, tx_valid, chop_phase, output tx_ready);
`else
  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave  (input tx_data, tx_valid, output tx_ready);
`endif
endinterface

// File: rtl/adc_chan_tx.sv
// adc_chan_tx: DDR serial ADC-link emulator (ADC_clock = clk/4, 18-bit words, MSB first).
// Optional feature: ADC_TX_CHOP_EN adds chop_phase; chop_phase=0 sends the negated word.
module adc_chan_tx #(
  parameter int GAP_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  adc_chan_tx_if.slave tx,
  output logic         ADC_clock,
  output logic         ADC_serial_data,
  output logic         ADC_word_sync_n
);
  localparam int LP_GAP = GAP_CYCLES < 2 ? 2 : GAP_CYCLES;
  localparam int CW = $clog2((LP_GAP > 36 ? LP_GAP : 36) + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t r_state, w_state;
  logic [17:0] r_sr, w_sr, w_word;
  logic [CW-1:0] r_cnt, w_cnt;
  logic r_ready, w_ready, r_clk, w_clk, r_data, w_data, r_sync_n, w_sync_n;
  logic w_accept;
`ifdef ADC_TX_CHOP_EN
  assign w_word = tx.chop_phase ? tx.tx_data : ~tx.tx_data + 18'd1;
`else
  assign w_word = tx.tx_data;
`endif
  assign w_accept = tx.tx_valid && r_ready;
  // Outputs are registered one clk behind the phase counter: phase 0 of period 0 shows at accept+1.
  always_comb begin
    w_state = r_state;
    w_sr = r_sr;
    w_cnt = r_cnt;
    w_clk = r_clk;
    w_data = r_data;
    w_sync_n = r_sync_n;
    case (r_state)
      IDLE: if (w_accept) begin
        w_state = SHIFT;
        w_sr = w_word;
        w_cnt = '0;
      end
      SHIFT: begin
        w_cnt = r_cnt + CW'(1);
        case (r_cnt[1:0])
          2'd0: begin
            w_data = r_sr[17];
            w_sync_n = 1'b1;
          end
          2'd1: w_clk = 1'b1;
          2'd2: w_data = r_sr[16];
          default: begin
            w_clk = 1'b0;
            w_sr = {r_sr[15:0], 2'b00};
          end
        endcase
        if (r_cnt == CW'(35)) begin
          w_state = GAP;
          w_cnt = '0;
        end
      end
      default: begin
        w_clk = 1'b0;
        w_sync_n = 1'b0;
        w_cnt = r_cnt + CW'(1);
        if (r_cnt == CW'(LP_GAP - 1)) w_state = IDLE;
      end
    endcase
    w_ready = w_state == IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sr <= '0;
      r_cnt <= '0;
      r_ready <= 1'b0;
      r_clk <= 1'b0;
      r_data <= 1'b0;
      r_sync_n <= 1'b1;
    end else begin
      r_state <= w_state;
      r_sr <= w_sr;
      r_cnt <= w_cnt;
      r_ready <= w_ready;
      r_clk <= w_clk;
      r_data <= w_data;
      r_sync_n <= w_sync_n;
    end
  end
  assign tx.tx_ready = r_ready;
  assign ADC_clock = r_clk;
  assign ADC_serial_data = r_data;
  assign ADC_word_sync_n = r_sync_n;
endmodule
